// File: rtl/mpu_core_if.sv
// Board-side bundle for mpu_core: switch/button inputs, LED and seven-segment outputs.
interface mpu_core_if;
  logic [3:0] sw;
  logic [3:0] btn;
  logic [3:0] led;
  logic [6:0] seg12;
  logic [6:0] seg34;
  logic [1:0] seg_en;

  modport master (output sw, btn, input led, seg12, seg34, seg_en);
  modport slave  (input sw, btn, output led, seg12, seg34, seg_en);
endinterface

// File: rtl/mpu_core.sv
// Button-stepped nibble ALU with a 4-entry result file and two multiplexed 7-segment pairs.
// Optional button debounce is enabled by defining DEBOUNCE_EN.
module mpu_core #(
  parameter int unsigned REFRESH_DIV     = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic        clk,
  input logic        rst_n,
  mpu_core_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_OP, S_DST, S_A, S_B, S_DONE} state_t;

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t      state, state_nx;
  logic [2:0]  sync1, sync2, lvl, lvl_d, pulse;
  logic        ld_op, ld_dst, ld_a, ld_b, do_clear;
  logic [3:0]  op, a, b;
  logic [1:0]  dst;
  logic [7:0]  result, alu_y, a8, b8;
  logic [7:0]  regs [4];
  logic [3:0]  led_c, step_idx, dig12, dig34;
  logic [CW-1:0] ref_cnt;
  logic        seg_sel, sel_nx;
  logic [6:0]  seg12_q, seg34_q;
  logic        unused_ok;

  assign unused_ok = bus.btn[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl_d <= '0;
      pulse <= '0;
    end else begin
      sync1 <= bus.btn[2:0];
      sync2 <= sync1;
      lvl_d <= lvl;
      pulse <= lvl & ~lvl_d;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DBW-1:0] db_cnt [3];

  // A new level is accepted only after it has persisted for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  localparam int unsigned UNUSED_DB_CYCLES = DEBOUNCE_CYCLES;
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_op    = 1'b0;
    ld_dst   = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    do_clear = pulse[2];
    if (pulse[2] || pulse[1]) begin
      state_nx = S_IDLE;
    end else if (pulse[0]) begin
      case (state)
        S_IDLE: state_nx = S_OP;
        S_OP:   begin ld_op  = 1'b1; state_nx = S_DST;  end
        S_DST:  begin ld_dst = 1'b1; state_nx = S_A;    end
        S_A:    begin ld_a   = 1'b1; state_nx = S_B;    end
        S_B:    begin ld_b   = 1'b1; state_nx = S_DONE; end
        default: state_nx = S_IDLE;
      endcase
    end
    case (state)
      S_OP:    begin led_c = 4'b0001; step_idx = 4'd1; end
      S_DST:   begin led_c = 4'b0010; step_idx = 4'd2; end
      S_A:     begin led_c = 4'b0100; step_idx = 4'd3; end
      S_B:     begin led_c = 4'b1000; step_idx = 4'd4; end
      S_DONE:  begin led_c = 4'b1111; step_idx = 4'd0; end
      default: begin led_c = 4'b0000; step_idx = 4'd0; end
    endcase
  end

  assign bus.led = led_c;

  // b is taken straight from sw so the result is ready on the B->DONE edge.
  always_comb begin
    a8 = {4'h0, a};
    b8 = {4'h0, bus.sw};
    case (op)
      4'h0: alu_y = a8 + b8;
      4'h1: alu_y = a8 - b8;
      4'h2: alu_y = a8 * b8;
      4'h3: alu_y = a8 & b8;
      4'h4: alu_y = a8 | b8;
      4'h5: alu_y = a8 ^ b8;
      4'h6: alu_y = a8 << bus.sw[2:0];
      4'h7: alu_y = a8 >> bus.sw[2:0];
      4'h8: alu_y = {4'h0, ~a};
      4'h9: alu_y = (a8 > b8) ? a8 : b8;
      4'hA: alu_y = (a8 < b8) ? a8 : b8;
      4'hB: alu_y = (a8 > b8) ? 8'h01 : ((a8 == b8) ? 8'h00 : 8'hFF);
      default: alu_y = regs[bus.sw[1:0]];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0; dst <= '0; a <= '0; b <= '0; result <= '0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (do_clear) begin
      op <= '0; dst <= '0; a <= '0; b <= '0; result <= '0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (ld_op)  op  <= bus.sw;
      if (ld_dst) dst <= bus.sw[1:0];
      if (ld_a)   a   <= bus.sw;
      if (ld_b) begin
        b         <= bus.sw;
        result    <= alu_y;
        regs[dst] <= alu_y;
      end
    end
  end

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Segments are computed for the select value that will be live after this edge.
  always_comb begin
    sel_nx = seg_sel ^ (ref_cnt == CW'(REFRESH_DIV - 1));
    if (state inside {S_OP, S_DST, S_A, S_B})
      dig12 = sel_nx ? step_idx : bus.sw;
    else
      dig12 = sel_nx ? result[3:0] : result[7:4];
    dig34 = sel_nx ? {2'b00, dst} : op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      seg_sel <= 1'b0;
      seg12_q <= 7'h3F;
      seg34_q <= 7'h3F;
    end else begin
      ref_cnt <= (ref_cnt == CW'(REFRESH_DIV - 1)) ? '0 : ref_cnt + 1'b1;
      seg_sel <= sel_nx;
      seg12_q <= font(dig12);
      seg34_q <= font(dig34);
    end
  end

  assign bus.seg12  = seg12_q;
  assign bus.seg34  = seg34_q;
  assign bus.seg_en = {seg_sel, seg_sel};

endmodule

// File: tb/tb_mpu_core.sv
// Directed + randomized bench for mpu_core against a behavioural instruction-level model.
module tb_mpu_core;
  localparam int unsigned DIV = 8;
  localparam int unsigned DBC = 4;
`ifdef DEBOUNCE_EN
  localparam int unsigned LAT = 3 + DBC;
`else
  localparam int unsigned LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpu_core_if bus();
  mpu_core #(.REFRESH_DIV(DIV), .DEBOUNCE_CYCLES(DBC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int compared = 0;
  int mismatched = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model: 0 IDLE, 1 OP, 2 DST, 3 A, 4 B, 5 DONE
  int         ms;
  logic [3:0] m_op, m_a, m_b;
  logic [1:0] m_dst;
  logic [7:0] m_res;
  logic [7:0] m_r [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] led_of(input int s);
    case (s)
      1: return 4'b0001; 2: return 4'b0010; 3: return 4'b0100;
      4: return 4'b1000; 5: return 4'b1111; default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [3:0] av, input logic [3:0] bv);
    int x, y;
    x = av; y = bv;
    case (op)
      0: return 8'((x + y) % 256);
      1: return 8'((x - y + 256) % 256);
      2: return 8'((x * y) % 256);
      3: return 8'(av & bv);
      4: return 8'(av | bv);
      5: return 8'(av ^ bv);
      6: return 8'((x * (1 << (y % 8))) % 256);
      7: return 8'(x / (1 << (y % 8)));
      8: return 8'(15 - x);
      9: return 8'((x > y) ? x : y);
      10: return 8'((x < y) ? x : y);
      11: return (x > y) ? 8'd1 : ((x == y) ? 8'd0 : 8'd255);
      default: return m_r[y % 4];
    endcase
  endfunction

  task automatic m_reset();
    ms = 0; m_op = 0; m_a = 0; m_b = 0; m_dst = 0; m_res = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  task automatic m_apply(input logic [2:0] which, input logic [3:0] s);
    if (which[2]) m_reset();
    else if (which[1]) ms = 0;
    else if (which[0]) begin
      case (ms)
        0: ms = 1;
        1: begin m_op = s; ms = 2; end
        2: begin m_dst = s[1:0]; ms = 3; end
        3: begin m_a = s; ms = 4; end
        4: begin m_b = s; m_res = ref_alu(m_op, m_a, m_b); m_r[m_dst] = m_res; ms = 5; end
        default: ms = 0;
      endcase
    end
  endtask

  task automatic press(input logic [2:0] which, input string tag);
    @(negedge clk);
    bus.btn = {1'b0, which};
    repeat (LAT + 5) @(negedge clk);
    bus.btn = 4'b0000;
    m_apply(which, bus.sw);
    repeat (LAT + 5) @(negedge clk);
    chk({tag, ".led"}, bus.led, led_of(ms));
  endtask

  task automatic step_sw(input logic [3:0] s, input string tag);
    @(negedge clk);
    bus.sw = s;
    press(3'b001, tag);
  endtask

  task automatic check_disp(input string tag);
    logic [3:0] d12 [2];
    logic [3:0] d34 [2];
    bit found;
    d12[0] = (ms >= 1 && ms <= 4) ? bus.sw : m_res[7:4];
    d12[1] = (ms >= 1 && ms <= 4) ? 4'(ms) : m_res[3:0];
    d34[0] = m_op;
    d34[1] = {2'b00, m_dst};
    for (int t = 0; t < 2; t++) begin
      found = 0;
      for (int i = 0; i < 4 * DIV; i++) begin
        @(posedge clk); #1;
        if (bus.seg_en === {t[0], t[0]}) begin found = 1; break; end
      end
      chk($sformatf("%s.sel%0d_seen", tag, t), 32'(found), 32'd1);
      if (found) begin
        chk($sformatf("%s.seg12_d%0d", tag, t), bus.seg12, glyph[d12[t]]);
        chk($sformatf("%s.seg34_d%0d", tag, t), bus.seg34, glyph[d34[t]]);
      end
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] d, input logic [3:0] av,
                           input logic [3:0] bv, input string tag);
    press(3'b001, {tag, ".go"});
    step_sw(op, {tag, ".op"});
    step_sw(d, {tag, ".dst"});
    step_sw(av, {tag, ".a"});
    step_sw(bv, {tag, ".b"});
    check_disp({tag, ".done"});
    press(3'b001, {tag, ".idle"});
  endtask

  task automatic read_regs(input string tag);
    for (int k = 0; k < 4; k++)
      run_instr(4'hC, 4'(k), 4'h0, 4'(k), $sformatf("%s.R%0d", tag, k));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sw = 4'h0;
    bus.btn = 4'h0;
    m_reset();
    #22;
    chk("rst.led", bus.led, 4'b0000);
    chk("rst.seg12", bus.seg12, 7'h3F);
    chk("rst.seg34", bus.seg34, 7'h3F);
    chk("rst.seg_en", bus.seg_en, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    check_disp("post_rst");

    // exact press latency on the first step
    @(negedge clk);
    bus.btn = 4'b0001;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1 chk("lat.before", bus.led, 4'b0000);
    @(posedge clk);
    #1 chk("lat.at", bus.led, 4'b0001);
    repeat (LAT + 3) @(negedge clk);
    bus.btn = 4'b0000;
    m_apply(3'b001, bus.sw);
    repeat (LAT + 5) @(negedge clk);
    chk("lat.held_once", bus.led, 4'b0001);

    step_sw(4'h1, "p1.op");
    step_sw(4'h0, "p1.dst");
    step_sw(4'hA, "p1.a");
    @(negedge clk) bus.sw = 4'h7;
    check_disp("p1.live_sw");
    step_sw(4'h5, "p1.b");
    check_disp("p1.done");
    press(3'b001, "p1.idle");

    run_instr(4'h1, 4'h0, 4'hC, 4'h3, "sub_c3");
    run_instr(4'hA, 4'h3, 4'h5, 4'h8, "min");
    run_instr(4'h0, 4'h1, 4'hF, 4'hF, "add_ff");
    run_instr(4'h1, 4'h2, 4'h3, 4'h5, "sub_35");
    run_instr(4'h2, 4'h1, 4'hF, 4'hF, "mul_ff");
    run_instr(4'hB, 4'h2, 4'h3, 4'h5, "cmp_35");
    read_regs("rd1");

    // cancel while in A
    press(3'b001, "can.go");
    step_sw(4'h3, "can.op");
    step_sw(4'h2, "can.dst");
    press(3'b010, "can.cancel");
    check_disp("can.idle");
    read_regs("rd2");

    press(3'b100, "clr");
    check_disp("clr.idle");
    read_regs("rd3");

    // clear and step together, mid-entry with a stored result
    run_instr(4'h0, 4'h2, 4'h9, 4'h4, "pre_cs");
    press(3'b001, "cs.go");
    step_sw(4'h5, "cs.op");
    press(3'b101, "cs.both");
    check_disp("cs.idle");
    run_instr(4'hC, 4'h0, 4'h0, 4'h2, "cs.R2");

    for (int n = 0; n < 16; n++) begin
      logic [3:0] rop, rd, ra, rb;
      rop = 4'($urandom_range(0, 15));
      rd = 4'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        press(3'b001, $sformatf("rnd%0d.go", n));
        step_sw(rop, $sformatf("rnd%0d.op", n));
        press(3'b010, $sformatf("rnd%0d.cancel", n));
      end
      run_instr(rop, rd, ra, rb, $sformatf("rnd%0d", n));
    end
    read_regs("rd4");

    // asynchronous reset while in B
    press(3'b001, "ar.go");
    step_sw(4'h2, "ar.op");
    step_sw(4'h1, "ar.dst");
    step_sw(4'h7, "ar.a");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar.led", bus.led, 4'b0000);
    chk("ar.seg12", bus.seg12, 7'h3F);
    chk("ar.seg34", bus.seg34, 7'h3F);
    chk("ar.seg_en", bus.seg_en, 2'b00);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_disp("ar.post");
    run_instr(4'hC, 4'h1, 4'h0, 4'h1, "ar.R1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
